// File: rtl/adxl362_pkg.sv
// Shared command codes, FSM states and transmit-byte helpers for the ADXL362 SPI master.
package adxl362_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;
  localparam logic [7:0] CMD_FIFO  = 8'h0D;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    CS_IDLE
  } state_t;

  function automatic logic [7:0] cmd_byte(input logic rw, input logic fifo);
    if (rw && fifo) return CMD_FIFO;
    if (rw)         return CMD_READ;
    return CMD_WRITE;
  endfunction

  // Byte sent at frame position idx: address, then wdata for writes, 0x00 filler otherwise.
  function automatic logic [7:0] tx_byte(input int unsigned idx, input logic rw,
                                         input logic fifo, input logic [5:0] addr,
                                         input logic [7:0] wdata);
    if (rw && fifo)         return 8'h00;
    if (idx == 1)           return {2'b00, addr};
    if (idx == 2 && !rw)    return wdata;
    return 8'h00;
  endfunction

endpackage

// File: rtl/adxl362_spi_tick.sv
// Free-running divider that pulses tick once every CLK_DIV clocks while enabled.
module adxl362_spi_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !enable)
      cnt <= '0;
    else if (cnt == CW'(CLK_DIV - 1))
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

  assign tick = enable && (cnt == CW'(CLK_DIV - 1));

endmodule

// File: rtl/adxl362_spi_master.sv
// SPI mode-0 master for the ADXL362: single-byte writes and burst reads.
// Define ADXL362_FIFO_READ_EN to add the fifo input and 0x0D FIFO burst reads.
module adxl362_spi_master
  import adxl362_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int MAX_LEN_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 rw,
  input  logic [5:0]           address,
  input  logic [7:0]           wdata,
  input  logic [MAX_LEN_W-1:0] len,
`ifdef ADXL362_FIFO_READ_EN
  input  logic                 fifo,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           rdata,
  output logic                 rdata_valid,
  output logic                 SCLK,
  output logic                 MOSI,
  output logic                 nCS,
  input  logic                 MISO
);

  localparam int LW = MAX_LEN_W + 1;

  state_t               state, state_n;
  logic                 tick, accept, rise, fall, last_byte, data_byte, rx_pend, fifo_sel;
  logic                 rw_q, fifo_q;
  logic [5:0]           addr_q;
  logic [7:0]           wdata_q, tx_sh, rx_sh, next_tx, cmd;
  logic [MAX_LEN_W-1:0] len_q;
  logic [2:0]           bit_cnt;
  logic [LW-1:0]        byte_cnt, len_eff, last_idx, first_idx;

`ifdef ADXL362_FIFO_READ_EN
  assign fifo_sel = fifo;
`else
  assign fifo_sel = 1'b0;
`endif

  adxl362_spi_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .enable (state != IDLE),
    .tick   (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    accept    = 1'b0;
    rise      = 1'b0;
    fall      = 1'b0;
    cmd       = cmd_byte(rw, fifo_sel);
    len_eff   = (len_q == '0) ? (LW'(1) << MAX_LEN_W) : {1'b0, len_q};
    last_idx  = LW'(2);
    first_idx = '1;
    if (rw_q && fifo_q) begin
      last_idx  = len_eff;
      first_idx = LW'(1);
    end else if (rw_q) begin
      last_idx  = len_eff + LW'(1);
      first_idx = LW'(2);
    end
    last_byte = (byte_cnt == last_idx);
    data_byte = rw_q && (byte_cnt >= first_idx);
    next_tx   = tx_byte(32'(byte_cnt) + 32'd1, rw_q, fifo_q, addr_q, wdata_q);
    case (state)
      IDLE: begin
        if (start && !busy) begin
          accept  = 1'b1;
          state_n = CS_SETUP;
        end
      end
      CS_SETUP: if (tick) state_n = SHIFT;
      SHIFT: begin
        rise = tick && !SCLK;
        fall = tick && SCLK;
        if (fall && bit_cnt == 3'd7 && last_byte) state_n = CS_HOLD;
      end
      CS_HOLD: if (tick) state_n = CS_IDLE;
      CS_IDLE: if (tick) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // busy stays high through the done cycle so a start coincident with done is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      SCLK        <= 1'b0;
      MOSI        <= 1'b0;
      nCS         <= 1'b1;
      rw_q        <= 1'b0;
      fifo_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      len_q       <= '0;
      tx_sh       <= '0;
      rx_sh       <= '0;
      bit_cnt     <= '0;
      byte_cnt    <= '0;
      rx_pend     <= 1'b0;
    end else begin
      done        <= 1'b0;
      rdata_valid <= rx_pend;
      rx_pend     <= 1'b0;
      if (rx_pend) rdata <= rx_sh;
      if (done)    busy  <= 1'b0;
      if (accept) begin
        rw_q     <= rw;
        fifo_q   <= fifo_sel;
        addr_q   <= address;
        wdata_q  <= wdata;
        len_q    <= len;
        tx_sh    <= cmd;
        MOSI     <= cmd[7];
        nCS      <= 1'b0;
        SCLK     <= 1'b0;
        busy     <= 1'b1;
        bit_cnt  <= '0;
        byte_cnt <= '0;
      end
      if (rise) begin
        SCLK  <= 1'b1;
        rx_sh <= {rx_sh[6:0], MISO};
        if (bit_cnt == 3'd7 && data_byte) rx_pend <= 1'b1;
      end
      if (fall) begin
        SCLK <= 1'b0;
        if (bit_cnt == 3'd7) begin
          bit_cnt <= '0;
          if (last_byte) begin
            MOSI <= 1'b0;
          end else begin
            byte_cnt <= byte_cnt + LW'(1);
            tx_sh    <= next_tx;
            MOSI     <= next_tx[7];
          end
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
          tx_sh   <= {tx_sh[6:0], 1'b0};
          MOSI    <= tx_sh[6];
        end
      end
      if (state == CS_HOLD && tick) begin
        nCS  <= 1'b1;
        MOSI <= 1'b0;
      end
      if (state == CS_IDLE && tick) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_adxl362_spi_master.sv
// Table-driven bench for adxl362_spi_master against a behavioural ADXL362 register-file slave.
// Define ADXL362_FIFO_READ_EN to also exercise FIFO burst reads.
module tb_adxl362_spi_master;

  localparam int CLK_DIV   = 4;
  localparam int MAX_LEN_W = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [5:0] address = '0;
  logic [7:0] wdata = '0;
  logic [3:0] len = '0;
`ifdef ADXL362_FIFO_READ_EN
  logic       fifo = 1'b0;
`endif
  logic       busy, done, rdata_valid, SCLK, MOSI, nCS, MISO;
  logic [7:0] rdata;

  adxl362_spi_master #(.CLK_DIV(CLK_DIV), .MAX_LEN_W(MAX_LEN_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .rw          (rw),
    .address     (address),
    .wdata       (wdata),
    .len         (len),
`ifdef ADXL362_FIFO_READ_EN
    .fifo        (fifo),
`endif
    .busy        (busy),
    .done        (done),
    .rdata       (rdata),
    .rdata_valid (rdata_valid),
    .SCLK        (SCLK),
    .MOSI        (MOSI),
    .nCS         (nCS),
    .MISO        (MISO)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rw;
    logic       fifo;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic [3:0] len;
    logic [7:0] expCmd;
    int         expSclk;
  } vec_t;

  int         compared = 0;
  int         mismatched = 0;
  int         doneCnt = 0;
  int         csLowCnt = 0;
  int         sclkRises = 0;
  bit         mosiIdleErr = 1'b0;
  logic [7:0] sbQ[$];
  logic [7:0] expMosi[$];
  logic [7:0] mosiBytes[$];
  logic [7:0] fifoQ[$];
  logic [7:0] regs[64];
  logic [7:0] shadow[64];

  // Behavioural slave: samples MOSI on rising SCLK, presents the next MISO bit right after.
  int         bitPos = 0;
  int         byteIdx = 0;
  logic [7:0] inSh = '0;
  logic [7:0] outByte = '0;
  logic [7:0] cmd = '0;
  logic [5:0] ptr = '0;

  assign MISO = (nCS !== 1'b0) ? 1'b0 : outByte[3'(7 - bitPos)];

  always @(negedge nCS) begin
    bitPos  = 0;
    byteIdx = 0;
    outByte = '0;
  end

  always @(posedge SCLK) begin
    sclkRises++;
    if (nCS === 1'b0) begin
      inSh = {inSh[6:0], MOSI};
      bitPos++;
      if (bitPos == 8) begin
        bitPos = 0;
        mosiBytes.push_back(inSh);
        if (byteIdx == 0) cmd = inSh;
        else if (byteIdx == 1 && cmd != 8'h0D) ptr = inSh[5:0];
        else if (byteIdx == 2 && cmd == 8'h0A) regs[ptr] = inSh;
        byteIdx++;
        outByte = '0;
        if (cmd == 8'h0B && byteIdx >= 2) begin
          outByte = regs[ptr];
          ptr = ptr + 6'd1;
        end else if (cmd == 8'h0D && byteIdx >= 1 && fifoQ.size() > 0) begin
          outByte = fifoQ.pop_front();
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard: every rdata_valid pulse must match the oldest expected byte.
  always @(negedge clk) begin
    if (done === 1'b1) doneCnt++;
    if (nCS === 1'b0) csLowCnt++;
    if (nCS === 1'b1 && MOSI !== 1'b0) mosiIdleErr = 1'b1;
    if (rdata_valid === 1'b1) begin
      if (sbQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL rdata_unexpected: actual=0x%0h expected=none", rdata);
      end else begin
        checkOutput("rdata", rdata, sbQ.pop_front());
      end
    end
  end

  function automatic logic [7:0] initReg(input int a);
    if (a == 0) return 8'hAD;
    if (a >= 'h0E && a <= 'h13) return 8'(16 + a - 'h0E);
    return 8'(a * 7 + 3);
  endfunction

  task automatic applyStimulus(input logic r, input logic fifoSel, input logic [5:0] addr,
                               input logic [7:0] wd, input logic [3:0] ln, input logic [7:0] cmdExp);
    int lenEff;
    lenEff = (ln == 0) ? 16 : int'(ln);
    doneCnt = 0;
    csLowCnt = 0;
    sclkRises = 0;
    mosiIdleErr = 1'b0;
    mosiBytes.delete();
    expMosi.delete();
    expMosi.push_back(cmdExp);
    if (!(r && fifoSel)) expMosi.push_back({2'b00, addr});
    if (!r) begin
      expMosi.push_back(wd);
      shadow[addr] = wd;
    end else begin
      for (int i = 0; i < lenEff; i++) begin
        expMosi.push_back(8'h00);
        if (!fifoSel) sbQ.push_back(shadow[6'(int'(addr) + i)]);
      end
    end
    @(negedge clk);
    start = 1'b1;
    rw = r;
    address = addr;
    wdata = wd;
    len = ln;
`ifdef ADXL362_FIFO_READ_EN
    fifo = fifoSel;
`endif
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic checkFrame(input string name, input int expSclk, input bit pokeOnDone);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4000 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s_timeout: actual=no_done expected=done", name);
    end
    if (seen && pokeOnDone) begin
      start = 1'b1;
      rw = 1'b0;
      address = 6'h05;
      wdata = 8'h77;
    end
    @(negedge clk);
    start = 1'b0;
    checkOutput($sformatf("%s_busy_clear", name), busy, 0);
    checkOutput($sformatf("%s_done_count", name), doneCnt, 1);
    checkOutput($sformatf("%s_sclk_rises", name), sclkRises, expSclk);
    checkOutput($sformatf("%s_ncs_low_cycles", name), csLowCnt, CLK_DIV * (2 + 2 * expSclk));
    checkOutput($sformatf("%s_mosi_bytes", name), mosiBytes.size(), expMosi.size());
    for (int i = 0; i < expMosi.size() && i < mosiBytes.size(); i++)
      checkOutput($sformatf("%s_mosi%0d", name, i), mosiBytes[i], expMosi[i]);
    checkOutput($sformatf("%s_sb_drained", name), sbQ.size(), 0);
    checkOutput($sformatf("%s_mosi_idle", name), mosiIdleErr, 0);
  endtask

  vec_t vecs[7];

  initial begin
    bit reached;
    vecs[0] = '{"wr_2d",      1'b0, 1'b0, 6'h2D, 8'h02, 4'd0, 8'h0A, 24};
    vecs[1] = '{"rd_devid",   1'b1, 1'b0, 6'h00, 8'h00, 4'd1, 8'h0B, 24};
    vecs[2] = '{"rd_burst6",  1'b1, 1'b0, 6'h0E, 8'hFF, 4'd6, 8'h0B, 64};
    vecs[3] = '{"rd_back_2d", 1'b1, 1'b0, 6'h2D, 8'h00, 4'd1, 8'h0B, 24};
    vecs[4] = '{"rd_len0",    1'b1, 1'b0, 6'h20, 8'h00, 4'd0, 8'h0B, 144};
    vecs[5] = '{"wr_1f",      1'b0, 1'b0, 6'h1F, 8'hA5, 4'd9, 8'h0A, 24};
    vecs[6] = '{"rd_back_1f", 1'b1, 1'b0, 6'h1F, 8'h00, 4'd2, 8'h0B, 32};
    for (int a = 0; a < 64; a++) begin
      regs[a]   = initReg(a);
      shadow[a] = initReg(a);
    end

    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_rdata_valid", rdata_valid, 0);
    checkOutput("rst_sclk", SCLK, 0);
    checkOutput("rst_mosi", MOSI, 0);
    checkOutput("rst_ncs", nCS, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].rw, vecs[v].fifo, vecs[v].addr, vecs[v].wdata, vecs[v].len, vecs[v].expCmd);
      checkFrame(vecs[v].name, vecs[v].expSclk, 1'b0);
    end

    // A second start mid-frame must not disturb the running write.
    applyStimulus(1'b0, 1'b0, 6'h33, 8'h5C, 4'd0, 8'h0A);
    repeat (60) @(negedge clk);
    start = 1'b1;
    rw = 1'b1;
    address = 6'h11;
    len = 4'd3;
    @(negedge clk);
    start = 1'b0;
    checkFrame("mid_start", 24, 1'b0);
    applyStimulus(1'b1, 1'b0, 6'h33, 8'h00, 4'd1, 8'h0B);
    checkFrame("rd_back_33", 24, 1'b1);
    doneCnt = 0;
    csLowCnt = 0;
    repeat (40) @(negedge clk);
    checkOutput("start_on_done_ncs", csLowCnt, 0);
    checkOutput("start_on_done_no_done", doneCnt, 0);
    checkOutput("start_on_done_busy", busy, 0);

    // Synchronous reset during the address byte aborts the frame without done.
    applyStimulus(1'b1, 1'b0, 6'h0E, 8'h00, 4'd6, 8'h0B);
    reached = 1'b0;
    for (int i = 0; i < 2000 && !reached; i++) begin
      @(negedge clk);
      if (byteIdx == 1 && bitPos == 4) reached = 1'b1;
    end
    checkOutput("rst_mid_reached", reached, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_mid_ncs", nCS, 1);
    checkOutput("rst_mid_sclk", SCLK, 0);
    checkOutput("rst_mid_mosi", MOSI, 0);
    checkOutput("rst_mid_busy", busy, 0);
    checkOutput("rst_mid_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    sbQ.delete();
    doneCnt = 0;
    repeat (60) @(negedge clk);
    checkOutput("rst_mid_no_done", doneCnt, 0);
    checkOutput("rst_mid_ncs_idle", nCS, 1);
    applyStimulus(1'b0, 1'b0, 6'h2C, 8'h0A, 4'd0, 8'h0A);
    checkFrame("wr_after_rst", 24, 1'b0);

`ifdef ADXL362_FIFO_READ_EN
    fifoQ.push_back(8'h81);
    fifoQ.push_back(8'h40);
    sbQ.push_back(8'h81);
    sbQ.push_back(8'h40);
    applyStimulus(1'b1, 1'b1, 6'h00, 8'h00, 4'd2, 8'h0D);
    checkFrame("fifo_rd", 24, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
